// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
//
// Assembles three consecutive bytes from a UART receiver into one 24-bit
// command. Bytes are taken whenever the receiver raises rx_rdy and consumed
// with a one-cycle clr_rx_rdy pulse. Once a full frame is held, further bytes
// are back-pressured (left pending in the receiver) until the consumer
// acknowledges with clr_cmd_rdy. A partial frame that stalls for TIMEOUT_CYC
// cycles is dropped and reported with a one-cycle frame_err pulse.
//
// Parameters:
//   TIMEOUT_CYC  inter-byte timeout in clk cycles (valid range 2..2^20-1)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_data      receiver byte, valid while rx_rdy is high
//   rx_rdy       receiver byte-ready level, held until clr_rx_rdy
//   clr_rx_rdy   one-cycle pulse consuming the current receiver byte
//   cmd          assembled command, first byte in [23:16]
//   cmd_rdy      level, cmd holds a complete frame
//   clr_cmd_rdy  consumer acknowledge, only honoured while a frame is held
//   frame_err    one-cycle pulse, partial frame dropped on timeout

module uart_cmd_framer #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        StIdle,
        StGot1,
        StGot2,
        StHold
    } state_t;

    state_t      state_q;
    logic [19:0] tmo_cnt_q;
    logic        accept;
    logic        tmo_expired;

    // rx_rdy is still high during the clr_rx_rdy cycle (the receiver only
    // drops it after seeing the pulse), so that cycle must not count as a
    // fresh byte. In HOLD the byte is left pending in the receiver.
    assign accept      = rx_rdy && !clr_rx_rdy && (state_q != StHold);
    assign tmo_expired = (tmo_cnt_q == TIMEOUT_CYC - 20'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cmd        <= 24'h000000;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b0;
            frame_err  <= 1'b0;
            tmo_cnt_q  <= 20'd0;
        end else begin
            clr_rx_rdy <= accept;
            frame_err  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    tmo_cnt_q <= 20'd0;
                    if (accept) begin
                        cmd[23:16] <= rx_data;
                        state_q    <= StGot1;
                    end
                end

                // In the mid-frame states an accept on the expiry edge wins
                // over the timeout.
                StGot1: begin
                    if (accept) begin
                        cmd[15:8] <= rx_data;
                        tmo_cnt_q <= 20'd0;
                        state_q   <= StGot2;
                    end else if (tmo_expired) begin
                        tmo_cnt_q <= 20'd0;
                        frame_err <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 20'd1;
                    end
                end

                StGot2: begin
                    if (accept) begin
                        cmd[7:0]  <= rx_data;
                        cmd_rdy   <= 1'b1;
                        tmo_cnt_q <= 20'd0;
                        state_q   <= StHold;
                    end else if (tmo_expired) begin
                        tmo_cnt_q <= 20'd0;
                        frame_err <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 20'd1;
                    end
                end

                // cmd is not cleared on release; the next frame overwrites
                // it byte by byte.
                StHold: begin
                    tmo_cnt_q <= 20'd0;
                    if (clr_cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer (TIMEOUT_CYC = 16).
// Directed scenarios plus a randomized byte stream checked against a
// frame-level model: bytes fill cmd left to right, a frame completes on the
// third byte, and a partial frame is dropped when the next accept comes more
// than TIMEOUT_CYC edges after the previous one.

module tb_uart_cmd_framer;

    localparam logic [19:0] TMO = 20'd16;
    localparam int          T   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        frame_err;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int clr_cnt = 0;
    int fe_q[$];

    uart_cmd_framer #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    // One clock; outputs sampled 1 ns after the rising edge. cyc is the index
    // of the edge just taken.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (clr_rx_rdy) clr_cnt++;
        if (frame_err) begin
            fe_q.push_back(cyc);
            checks++;
            if (cmd_rdy !== 1'b0) begin
                errors++;
                $display("FAIL excl: cmd_rdy=%b with frame_err at cyc %0d, want 0", cmd_rdy, cyc);
            end
        end
    endtask

    // Receiver model: present a byte after 'gap' idle cycles (or use the byte
    // already pending when pre=1), hold rx_rdy until clr_rx_rdy is seen.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pre, output int acc);
        bit got;
        acc = -1;
        got = 1'b0;
        if (!pre) begin
            repeat (gap) tick();
            rx_data = b;
            rx_rdy  = 1'b1;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (clr_rx_rdy) begin
                got    = 1'b1;
                acc    = cyc;
                rx_rdy = 1'b0;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_wait: byte %h consumed=0 after 100 cycles, want 1", b);
            rx_rdy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        rst_n       = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        fe_q.delete();
        clr_cnt = 0;
    endtask

    task automatic test_reset();
        #3;
        checks += 4;
        if (cmd !== 24'h000000) begin errors++; $display("FAIL rst_cmd: got %h want 000000", cmd); end
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_cmd_rdy: got %b want 0", cmd_rdy); end
        if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL rst_clr: got %b want 0", clr_rx_rdy); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        do_reset();
    endtask

    task automatic test_basic();
        int a;
        int c0;
        c0 = clr_cnt;
        send_byte(8'h08, 2, 1'b0, a);
        send_byte(8'h2A, 0, 1'b0, a);
        send_byte(8'hBB, 3, 1'b0, a);
        checks += 2;
        if (cmd !== 24'h082ABB) begin errors++; $display("FAIL basic_cmd: got %h want 082ABB", cmd); end
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy: got %b want 1", cmd_rdy); end
        tick();
        checks += 2;
        if (clr_cnt - c0 != 3) begin errors++; $display("FAIL basic_pulses: got %0d want 3", clr_cnt - c0); end
        if (fe_q.size() != 0) begin errors++; $display("FAIL basic_ferr: got %0d pulses want 0", fe_q.size()); end
    endtask

    // Continues from the HOLD state left by test_basic.
    task automatic test_hold();
        int a;
        int c0;
        int l;
        rx_data = 8'h09;
        rx_rdy  = 1'b1;
        c0 = clr_cnt;
        repeat (50) tick();
        checks += 3;
        if (clr_cnt != c0) begin errors++; $display("FAIL hold_bp: got %0d pulses want 0", clr_cnt - c0); end
        if (cmd !== 24'h082ABB) begin errors++; $display("FAIL hold_cmd: got %h want 082ABB", cmd); end
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL hold_rdy: got %b want 1", cmd_rdy); end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        l = cyc;
        checks++;
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", cmd_rdy); end
        send_byte(8'h09, 0, 1'b1, a);
        checks += 3;
        if (a <= l) begin errors++; $display("FAIL hold_early: accept edge %0d want > %0d", a, l); end
        if (cmd !== 24'h092ABB) begin errors++; $display("FAIL hold_byte1: got %h want 092ABB", cmd); end
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL hold_got1_rdy: got %b want 0", cmd_rdy); end
        send_byte(8'hC3, 1, 1'b0, a);
        send_byte(8'h3C, 0, 1'b0, a);
        checks += 2;
        if (cmd !== 24'h09C33C) begin errors++; $display("FAIL hold_next: got %h want 09C33C", cmd); end
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL hold_next_rdy: got %b want 1", cmd_rdy); end
        do_reset();
    endtask

    task automatic test_timeout();
        int a;
        int a2;
        send_byte(8'h01, 1, 1'b0, a);
        send_byte(8'h00, 0, 1'b0, a2);
        repeat (20) tick();
        checks += 2;
        if (fe_q.size() != 1) begin
            errors++;
            $display("FAIL tmo_count: got %0d pulses want 1", fe_q.size());
        end else begin
            checks++;
            if (fe_q[0] != a2 + T) begin
                errors++;
                $display("FAIL tmo_time: pulse at edge %0d want %0d", fe_q[0], a2 + T);
            end
        end
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL tmo_rdy: got %b want 0", cmd_rdy); end
        send_byte(8'h05, 0, 1'b0, a);
        send_byte(8'hFF, 0, 1'b0, a);
        send_byte(8'h02, 0, 1'b0, a);
        checks += 3;
        if (cmd !== 24'h05FF02) begin errors++; $display("FAIL tmo_next: got %h want 05FF02", cmd); end
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL tmo_next_rdy: got %b want 1", cmd_rdy); end
        if (fe_q.size() != 1) begin errors++; $display("FAIL tmo_extra: got %0d pulses want 1", fe_q.size()); end
        do_reset();
    endtask

    task automatic test_expiry_race();
        int a1;
        int a2;
        send_byte(8'h11, 0, 1'b0, a1);
        send_byte(8'h22, T - 1, 1'b0, a2);
        checks += 2;
        if (a2 - a1 != T) begin errors++; $display("FAIL race_edge: gap %0d want %0d", a2 - a1, T); end
        if (fe_q.size() != 0) begin errors++; $display("FAIL race_ferr: got %0d pulses want 0", fe_q.size()); end
        send_byte(8'h33, 0, 1'b0, a2);
        checks += 2;
        if (cmd !== 24'h112233) begin errors++; $display("FAIL race_cmd: got %h want 112233", cmd); end
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL race_rdy: got %b want 1", cmd_rdy); end
        do_reset();
    endtask

    task automatic test_async_reset();
        int a;
        send_byte(8'h12, 0, 1'b0, a);
        send_byte(8'h34, 0, 1'b0, a);
        #3;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (cmd !== 24'h000000) begin errors++; $display("FAIL arst_cmd: got %h want 000000", cmd); end
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL arst_rdy: got %b want 0", cmd_rdy); end
        if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL arst_clr: got %b want 0", clr_rx_rdy); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL arst_ferr: got %b want 0", frame_err); end
        #2;
        rst_n = 1'b1;
        fe_q.delete();
        repeat (20) tick();
        checks++;
        if (fe_q.size() != 0) begin errors++; $display("FAIL arst_tmo: got %0d pulses want 0", fe_q.size()); end
        send_byte(8'hAA, 0, 1'b0, a);
        send_byte(8'hBB, 0, 1'b0, a);
        send_byte(8'hCC, 0, 1'b0, a);
        checks += 2;
        if (cmd !== 24'hAABBCC) begin errors++; $display("FAIL arst_cmd2: got %h want AABBCC", cmd); end
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL arst_rdy2: got %b want 1", cmd_rdy); end
        do_reset();
    endtask

    task automatic test_clr_cmd_idle();
        int a;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        checks += 3;
        if (cmd !== 24'h000000) begin errors++; $display("FAIL ack_idle_cmd: got %h want 000000", cmd); end
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL ack_idle_rdy: got %b want 0", cmd_rdy); end
        if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL ack_idle_clr: got %b want 0", clr_rx_rdy); end
        send_byte(8'h5A, 0, 1'b0, a);
        tick();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        checks += 2;
        if (cmd !== 24'h5A0000) begin errors++; $display("FAIL ack_got1_cmd: got %h want 5A0000", cmd); end
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL ack_got1_rdy: got %b want 0", cmd_rdy); end
        send_byte(8'h6B, 0, 1'b0, a);
        send_byte(8'h7C, 0, 1'b0, a);
        checks += 2;
        if (cmd !== 24'h5A6B7C) begin errors++; $display("FAIL ack_got1_frame: got %h want 5A6B7C", cmd); end
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL ack_got1_done: got %b want 1", cmd_rdy); end
        do_reset();
    endtask

    task automatic test_random();
        int          a;
        int          g;
        int          last;
        int          n;
        int          nbytes;
        int          c0;
        int          c1;
        int          exp_fe;
        logic [23:0] m;
        bit          pend;
        logic [7:0]  b;
        logic [7:0]  pb;
        last   = 0;
        n      = 0;
        nbytes = 0;
        pend   = 1'b0;
        pb     = 8'h00;
        m      = 24'h000000;
        c0     = clr_cnt;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0:       b = 8'h00;
                1:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(T - 2, T + 2))
                                            : int'($urandom_range(0, 4));
            fe_q.delete();
            if (pend) begin
                b = pb;
                send_byte(b, 0, 1'b1, a);
                pend = 1'b0;
            end else begin
                send_byte(b, g, 1'b0, a);
            end
            nbytes++;
            exp_fe = (n > 0 && a - last > T) ? 1 : 0;
            if (exp_fe == 1) n = 0;
            checks++;
            if (fe_q.size() != exp_fe) begin
                errors++;
                $display("FAIL rnd_ferr: byte %0d got %0d pulses want %0d", it, fe_q.size(), exp_fe);
            end else if (exp_fe == 1) begin
                checks++;
                if (fe_q[0] != last + T) begin
                    errors++;
                    $display("FAIL rnd_ferr_time: byte %0d edge %0d want %0d", it, fe_q[0], last + T);
                end
            end
            m[23 - 8 * n -: 8] = b;
            n++;
            last = a;
            checks += 2;
            if (cmd !== m) begin errors++; $display("FAIL rnd_cmd: byte %0d got %h want %h", it, cmd, m); end
            if (cmd_rdy !== (n == 3)) begin
                errors++;
                $display("FAIL rnd_rdy: byte %0d got %b want %b", it, cmd_rdy, (n == 3));
            end
            if (n == 3) begin
                pend = 1'($urandom_range(0, 1));
                if (pend) begin
                    pb      = 8'($urandom);
                    rx_data = pb;
                    rx_rdy  = 1'b1;
                end
                c1 = clr_cnt;
                repeat ($urandom_range(1, 8)) tick();
                checks += 3;
                if (clr_cnt != c1) begin errors++; $display("FAIL rnd_bp: got %0d pulses want 0", clr_cnt - c1); end
                if (cmd !== m) begin errors++; $display("FAIL rnd_hold_cmd: got %h want %h", cmd, m); end
                if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rnd_hold_rdy: got %b want 1", cmd_rdy); end
                clr_cmd_rdy = 1'b1;
                tick();
                clr_cmd_rdy = 1'b0;
                checks++;
                if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rnd_release: got %b want 0", cmd_rdy); end
                n = 0;
            end
        end
        if (pend) begin
            send_byte(pb, 0, 1'b1, a);
            nbytes++;
        end
        tick();
        checks++;
        if (clr_cnt - c0 != nbytes) begin
            errors++;
            $display("FAIL rnd_pulses: got %0d want %0d", clr_cnt - c0, nbytes);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_expiry_race();
        test_async_reset();
        test_clr_cmd_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
